// File: rtl/iob_eth_tx_loader.sv
// Ethernet TX loader: writes preamble/SFD, payload and optional zero padding into a frame buffer, then hands the frame off.
// Latency: header takes PREAMBLE_LEN+1 cycles, payload bytes are written in the cycle they are accepted, and padding adds one byte per cycle.
// Backpressure: s_ready_o is high only in PAYLOAD/DISCARD; a new frame starts only when the transmitter reports idle.
module iob_eth_tx_loader #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int BUF_AW       = 11
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic              pad_en_i,
    input  logic              crc_en_i,
    output logic              buf_we_o,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic [7:0]        buf_data_o,
    output logic              send_o,
    input  logic              tx_ready_i,
    output logic [BUF_AW-1:0] nbytes_o,
    output logic              crc_en_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [BUF_AW-1:0] PTR_MAX   = '1;
    localparam logic [BUF_AW-1:0] HDR_LAST  = BUF_AW'(PREAMBLE_LEN);
    localparam logic [BUF_AW-1:0] PAY_START = BUF_AW'(PREAMBLE_LEN + 1);
    // One bit wider than the pointer so the pad threshold compare never wraps.
    localparam logic [BUF_AW:0]   PAD_END   = (BUF_AW + 1)'(PREAMBLE_LEN + 1 + MIN_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        PAD,
        SEND,
        WAIT_DONE,
        DISCARD
    } state_t;

    state_t            state;
    logic [BUF_AW-1:0] ptr;
    logic              pad_en_q;

    logic              accept;
    logic              at_max;
    logic [BUF_AW:0]   ptr_inc;
    logic              pad_needed;

    assign s_ready_o  = (state == PAYLOAD) || (state == DISCARD);
    assign accept     = s_valid_i && s_ready_o;
    assign at_max     = (ptr == PTR_MAX);
    assign ptr_inc    = {1'b0, ptr} + 1'b1;
    assign pad_needed = pad_en_q && (ptr_inc < PAD_END);
    assign busy_o     = (state != IDLE);
    assign buf_addr_o = ptr;
    // The frame is dropped on the cycle its last byte is swallowed in DISCARD.
    assign err_o      = (state == DISCARD) && accept && s_last_i;

    // Write strobe and data: header bytes, accepted payload bytes (except the overflowing one), and pad zeros.
    always_comb begin
        buf_we_o   = 1'b0;
        buf_data_o = 8'h00;
        case (state)
            HDR: begin
                buf_we_o   = 1'b1;
                buf_data_o = (ptr == HDR_LAST) ? 8'hD5 : 8'h55;
            end
            PAYLOAD: begin
                buf_we_o   = accept && (!at_max || s_last_i);
                buf_data_o = s_data_i;
            end
            PAD: begin
                buf_we_o   = 1'b1;
                buf_data_o = 8'h00;
            end
            default: begin
                buf_we_o   = 1'b0;
                buf_data_o = 8'h00;
            end
        endcase
    end

    // Frame sequencing, write pointer, and the registered per-frame outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            ptr      <= '0;
            pad_en_q <= 1'b0;
            crc_en_o <= 1'b0;
            nbytes_o <= '0;
            send_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid_i && tx_ready_i) begin
                        state    <= HDR;
                        pad_en_q <= pad_en_i;
                        crc_en_o <= crc_en_i;
                        ptr      <= '0;
                    end
                end
                HDR: begin
                    if (ptr == HDR_LAST) begin
                        ptr   <= PAY_START;
                        state <= PAYLOAD;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (s_last_i) begin
                            ptr <= ptr_inc[BUF_AW-1:0];
                            if (pad_needed) begin
                                state <= PAD;
                            end else begin
                                state    <= SEND;
                                send_o   <= 1'b1;
                                // A last byte at the top address saturates the count rather than wrapping.
                                nbytes_o <= at_max ? PTR_MAX : ptr_inc[BUF_AW-1:0];
                            end
                        end else if (at_max) begin
                            state <= DISCARD;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                PAD: begin
                    ptr <= ptr + 1'b1;
                    if (ptr_inc == PAD_END) begin
                        state    <= SEND;
                        send_o   <= 1'b1;
                        nbytes_o <= ptr_inc[BUF_AW-1:0];
                    end
                end
                SEND: begin
                    if (!tx_ready_i) begin
                        state  <= WAIT_DONE;
                        send_o <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready_i) begin
                        state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (accept && s_last_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_loader.sv
// Testbench for iob_eth_tx_loader: directed frames, expected buffer writes and frame outcomes queued up front,
// a negedge monitor pops and compares every write, send and error event.
module tb_iob_eth_tx_loader;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic        pad_en_i;
    logic        crc_en_i;
    logic        buf_we_o;
    logic [10:0] buf_addr_o;
    logic [7:0]  buf_data_o;
    logic        send_o;
    logic        tx_ready_i;
    logic [10:0] nbytes_o;
    logic        crc_en_o;
    logic        busy_o;
    logic        err_o;

    iob_eth_tx_loader #(
        .PREAMBLE_LEN(7),
        .MIN_PAYLOAD (60),
        .BUF_AW      (11)
    ) dut (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .pad_en_i  (pad_en_i),
        .crc_en_i  (crc_en_i),
        .buf_we_o  (buf_we_o),
        .buf_addr_o(buf_addr_o),
        .buf_data_o(buf_data_o),
        .send_o    (send_o),
        .tx_ready_i(tx_ready_i),
        .nbytes_o  (nbytes_o),
        .crc_en_o  (crc_en_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        bit          is_err;
        logic [10:0] nbytes;
        bit          crc;
    } fr_t;

    wr_t wq[$];
    fr_t fq[$];
    int  vectors    = 0;
    int  miscompares = 0;
    bit  send_prev  = 1'b0;
    wr_t mw;
    fr_t mf;

    function automatic void push_wr(int a, logic [7:0] d);
        wr_t w;
        w.addr = 11'(a);
        w.data = d;
        wq.push_back(w);
    endfunction

    function automatic void push_fr(bit e, int nb, bit c);
        fr_t f;
        f.is_err = e;
        f.nbytes = 11'(nb);
        f.crc    = c;
        fq.push_back(f);
    endfunction

    // Monitor: every buffer write, every rising send_o and every err_o pulse consumes one expectation.
    always @(negedge clk_i) begin
        if (!arst_i) begin
            if (buf_we_o) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", buf_addr_o, buf_data_o);
                end else begin
                    mw = wq.pop_front();
                    if (buf_addr_o !== mw.addr || buf_data_o !== mw.data) begin
                        miscompares++;
                        $display("FAIL wr: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 buf_addr_o, buf_data_o, mw.addr, mw.data);
                    end
                end
            end
            if (send_o && !send_prev) begin
                vectors++;
                if (fq.size() == 0) begin
                    miscompares++;
                    $display("FAIL send_unexpected: got send with nbytes=%0d, expected none", nbytes_o);
                end else begin
                    mf = fq.pop_front();
                    if (mf.is_err || nbytes_o !== mf.nbytes || crc_en_o !== mf.crc) begin
                        miscompares++;
                        $display("FAIL send: got nbytes=%0d crc=%0b, expected is_err=%0b nbytes=%0d crc=%0b",
                                 nbytes_o, crc_en_o, mf.is_err, mf.nbytes, mf.crc);
                    end
                end
            end
            if (err_o) begin
                vectors++;
                if (fq.size() == 0) begin
                    miscompares++;
                    $display("FAIL err_unexpected: got err_o=1, expected 0");
                end else begin
                    mf = fq.pop_front();
                    if (!mf.is_err) begin
                        miscompares++;
                        $display("FAIL err: got err_o=1, expected send with nbytes=%0d", mf.nbytes);
                    end
                end
            end
        end
        send_prev = send_o;
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit gap);
        bit ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_i);
            if (s_ready_o) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rdy_timeout: got s_ready_o=0 for 200 cycles, expected 1");
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (gap) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic run_frame(int n, bit pad, bit crc, bit toggle, int abort_at, int hold_low, int seed);
        int ptr = 8;
        bit ovf = 1'b0;
        int nb  = 0;
        bit seen = 1'b0;
        pad_en_i = pad;
        crc_en_i = crc;
        for (int j = 0; j < 8; j++) push_wr(j, (j == 7) ? 8'hD5 : 8'h55);
        for (int i = 0; i < n; i++) begin
            if (abort_at >= 0 && i >= abort_at) break;
            if (!ovf) begin
                if (ptr == 2047 && i != n - 1) begin
                    ovf = 1'b1;
                end else begin
                    push_wr(ptr, 8'(i + seed));
                    ptr++;
                end
            end
        end
        if (abort_at < 0) begin
            if (ovf) begin
                push_fr(1'b1, 0, 1'b0);
            end else begin
                if (pad) begin
                    while (ptr < 68) begin
                        push_wr(ptr, 8'h00);
                        ptr++;
                    end
                end
                nb = (ptr > 2047) ? 2047 : ptr;
                push_fr(1'b0, nb, crc);
            end
        end

        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                s_valid_i = 1'b1;
                s_data_i  = 8'(i + seed);
                arst_i    = 1'b1;
                @(negedge clk_i);
                check("abort_outputs",
                      64'({s_ready_o, buf_we_o, buf_addr_o, buf_data_o, send_o, nbytes_o, crc_en_o, busy_o, err_o}),
                      64'd0);
                @(posedge clk_i);
                #1;
                arst_i    = 1'b0;
                s_valid_i = 1'b0;
                check("abort_flush", 64'(wq.size()), 64'd0);
                return;
            end
            send_byte(8'(i + seed), i == n - 1, toggle);
        end

        if (ovf) begin
            @(negedge clk_i);
            check("discard_idle", 64'({busy_o, s_ready_o, send_o}), 64'd0);
            return;
        end

        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk_i);
            if (send_o) seen = 1'b1;
        end
        check("send_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("send_hold", 64'({send_o, busy_o, s_ready_o, nbytes_o}), 64'({1'b1, 1'b1, 1'b0, 11'(nb)}));
        end
        @(posedge clk_i);
        #1;
        tx_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < hold_low; k++) begin
            @(negedge clk_i);
            check("wait_done", 64'({send_o, s_ready_o, busy_o, nbytes_o, crc_en_o}),
                  64'({1'b0, 1'b0, 1'b1, 11'(nb), crc}));
        end
        @(posedge clk_i);
        #1;
        tx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("back_idle", 64'({busy_o, send_o}), 64'd0);
    endtask

    initial begin
        arst_i     = 1'b1;
        s_valid_i  = 1'b0;
        s_data_i   = 8'h00;
        s_last_i   = 1'b0;
        pad_en_i   = 1'b0;
        crc_en_i   = 1'b0;
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        check("reset_outputs",
              64'({s_ready_o, buf_we_o, buf_addr_o, buf_data_o, send_o, nbytes_o, crc_en_o, busy_o, err_o}),
              64'd0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;

        run_frame(64,   1'b1, 1'b1, 1'b0, -1, 2,  8'h00);
        run_frame(10,   1'b1, 1'b0, 1'b0, -1, 2,  8'hA0);
        run_frame(10,   1'b0, 1'b1, 1'b0, -1, 2,  8'h10);
        run_frame(2100, 1'b0, 1'b0, 1'b0, -1, 0,  8'h33);
        run_frame(64,   1'b0, 1'b0, 1'b0, -1, 2,  8'h40);
        run_frame(20,   1'b0, 1'b1, 1'b1, -1, 20, 8'h80);
        run_frame(64,   1'b1, 1'b1, 1'b0, 30, 0,  8'h11);
        run_frame(64,   1'b1, 1'b0, 1'b0, -1, 2,  8'h22);
        run_frame(2040, 1'b0, 1'b1, 1'b0, -1, 2,  8'h05);

        repeat (4) @(negedge clk_i);
        check("wr_queue_empty", 64'(wq.size()), 64'd0);
        check("fr_queue_empty", 64'(fq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by 2000000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_eth_tx_loader.md
IOB_ETH_TX_LOADER -- requirements
Module: iob_eth_tx_loader

Interface
REQ-001 Parameters: PREAMBLE_LEN, default 7, count of 0x55 preamble bytes before SFD; MIN_PAYLOAD, default 60, minimum bytes after SFD when padding enabled; BUF_AW, default 11, buffer address width.
REQ-002 Ports:
 clk_i  in  1  clock; all logic on rising edge.
 arst_i  in  1  reset; asynchronous, active-high.
 s_valid_i  in  1  payload byte valid.
 s_data_i  in  8  payload byte.
 s_last_i  in  1  marks final payload byte of frame.
 s_ready_o  out  1  loader accepts byte this cycle.
 pad_en_i  in  1  pad short frames; sampled at frame start.
 crc_en_i  in  1  request FCS append; sampled at frame start.
 buf_we_o  out  1  buffer write strobe.
 buf_addr_o  out  BUF_AW  buffer write address.
 buf_data_o  out  8  buffer write data.
 send_o  out  1  frame ready for transmitter.
 tx_ready_i  in  1  transmitter idle (high) / busy (low).
 nbytes_o  out  BUF_AW  total bytes in buffer, header included.
 crc_en_o  out  1  latched crc_en_i for current frame.
 busy_o  out  1  loader not in IDLE.
 err_o  out  1  one-cycle pulse: frame dropped for overflow.

Function
REQ-003 States: IDLE, HDR, PAYLOAD, PAD, SEND, WAIT_DONE, DISCARD.
REQ-004 IDLE: s_ready_o=0; on s_valid_i=1 and tx_ready_i=1 -> HDR, latch pad_en_i/crc_en_i, pointer=0.
REQ-005 HDR: exactly PREAMBLE_LEN+1 cycles, one write per cycle, addresses 0..PREAMBLE_LEN; data 0x55, last byte 0xD5; s_ready_o=0; then -> PAYLOAD with pointer=PREAMBLE_LEN+1.
REQ-006 PAYLOAD: s_ready_o=1; each s_valid_i&s_ready_o cycle writes s_data_i at pointer, same cycle, then pointer increments by 1.
REQ-007 Accepted byte with s_last_i=1: if padding latched and pointer+1 < PREAMBLE_LEN+1+MIN_PAYLOAD -> PAD, else -> SEND.
REQ-008 PAD: s_ready_o=0; writes 0x00 one byte per cycle until pointer equals PREAMBLE_LEN+1+MIN_PAYLOAD, then -> SEND.
REQ-009 nbytes_o: updated on entry to SEND to final pointer value (bytes written); held constant until next HDR entry.
REQ-010 SEND: send_o=1; held until tx_ready_i=0 sampled, then -> WAIT_DONE with send_o=0 next cycle.
REQ-011 WAIT_DONE: no writes, s_ready_o=0; on tx_ready_i=1 -> IDLE.
REQ-012 Overflow: byte accepted in PAYLOAD when pointer = 2^BUF_AW-1 without s_last_i -> DISCARD, no write for that byte; err_o not yet.
REQ-013 DISCARD: s_ready_o=1, no writes; on accepted s_last_i -> IDLE, err_o=1 for that one cycle, send_o never asserted for the frame.
REQ-014 Accepted s_last_i with pointer=2^BUF_AW-1 writes normally -> SEND/PAD rule (nbytes=2^BUF_AW-1 max representable).
REQ-015 buf_we_o high only in HDR, PAD, and accepted PAYLOAD cycles; buf_addr_o/buf_data_o don't-care otherwise.
REQ-016 crc_en_o reflects latched value, stable from HDR until next HDR.
REQ-017 busy_o=1 in every state except IDLE.
REQ-018 s_valid_i low in PAYLOAD: no write, pointer holds, no timeout.

Reset
REQ-019 arst_i asserted at any time, including mid-frame or in SEND: immediate return to IDLE; pointer=0, nbytes_o=0, crc_en_o=0, send_o=0, buf_we_o=0, s_ready_o=0, err_o=0, busy_o=0, buf_addr_o=0, buf_data_o=0.
REQ-020 Partial frame after reset is abandoned; no send_o for it.

Verification
REQ-021 Payload 64 bytes 0x00..0x3F, pad_en=1, crc_en=1 -> buffer 0..6=0x55, 7=0xD5, 8..71=payload; nbytes_o=72, crc_en_o=1, send_o until tx_ready_i low.
REQ-022 Payload 10 bytes, pad_en=1 -> addresses 18..67 written 0x00; nbytes_o=68.
REQ-023 Payload 10 bytes, pad_en=0 -> no padding, nbytes_o=18.
REQ-024 Payload 2100 bytes, BUF_AW=11 -> no send_o, err_o one pulse on last-byte cycle, return to IDLE; next 64-byte frame transmits normally.
REQ-025 s_valid_i toggled every other cycle in PAYLOAD -> no gaps or duplicates in buffer; tx_ready_i held low for 20 cycles after send -> loader stays WAIT_DONE, s_ready_o=0.
REQ-026 arst_i pulsed during PAYLOAD byte 30 -> all outputs reset values next edge; new frame restarts at address 0.
